// File: rtl/popcount_sched_pkg.sv
// Shared constants and FSM encoding for the popcount scheduler.
package popcount_sched_pkg;
    localparam int CHUNK_W    = 7;
    localparam int CHUNKS_DEF = 4;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/popcount_sched_ones.sv
// Shared 7-input ones counter (purely combinational).
module ones (
    input  logic [6:0] din,
    output logic [2:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < 7; i++) count = count + {2'b00, din[i]};
    end
endmodule

// File: rtl/popcount_sched.sv
// Round-robin scheduler serialising two requesters' words through one shared ones counter.
//   state | meaning
//   IDLE  | arbitrate; granted ready driven combinationally, word latched
//   RUN   | one chunk per cycle through ones, accumulate
//   DONE  | result presented until consumer takes it
module popcount_sched
    import popcount_sched_pkg::*;
#(
    parameter int CHUNKS = CHUNKS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic [CHUNK_W*CHUNKS-1:0] req0_data,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [CHUNK_W*CHUNKS-1:0] req1_data,
    output logic                      req1_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [CNT_W-1:0]          res_count,
    output logic                      res_id
);
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    state_t                           state;
    logic [CHUNKS-1:0][CHUNK_W-1:0]   word;
    logic [IDX_W-1:0]                 idx;
    logic [CNT_W-1:0]                 acc;
    logic                             last_grant;
    logic                             grant0;
    logic                             grant1;
    logic [CHUNK_W-1:0]               chunk;
    logic [2:0]                       ones_cnt;
    logic [CNT_W-1:0]                 sum;

    // Readies are masked by reset so they read 0 while rst_n is held low.
    always_comb begin
        grant0 = rst_n && (state == IDLE) && req0_valid && (!req1_valid || last_grant);
        grant1 = rst_n && (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
        chunk  = word[idx];
        sum    = acc + CNT_W'(ones_cnt);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    ones u_ones (
        .din   (chunk),
        .count (ones_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word       <= '0;
            idx        <= '0;
            acc        <= '0;
            res_count  <= '0;
            res_id     <= 1'b0;
            res_valid  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        word       <= grant1 ? req1_data : req0_data;
                        res_id     <= grant1;
                        last_grant <= grant1;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(CHUNKS - 1)) begin
                        res_count <= sum;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_sched.sv
// Scoreboard bench for popcount_sched: random + directed words, reference popcount model.
module tb_popcount_sched;
    localparam int CHUNKS = 4;
    localparam int CNT_W  = 5;
    localparam int W      = 7 * CHUNKS;

    logic          clk;
    logic          rst_n;
    logic          v0, v1, r0, r1, rr;
    logic [W-1:0]  d0, d1;
    logic          rv;
    logic [CNT_W-1:0] rc;
    logic          rid;

    popcount_sched #(.CHUNKS(CHUNKS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_ready (r1),
        .res_valid  (rv),
        .res_ready  (rr),
        .res_count  (rc),
        .res_id     (rid)
    );

    typedef struct {
        logic id;
        int   cnt;
        int   t;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  acc_cnt = 0;
    int  res_cnt = 0;
    bit  acc0 = 0, acc1 = 0;
    int  valid_pct = 100;
    int  rr_pct = 100;
    bit  rr_hold = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: valids are sticky until accepted; data held while valid.
    initial begin
        v0 = 0; v1 = 0; d0 = '0; d1 = '0; rr = 1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                v0 = 0; v1 = 0; acc0 = 0; acc1 = 0;
            end else begin
                if (acc0) begin v0 = 0; acc0 = 0; end
                if (acc1) begin v1 = 0; acc1 = 0; end
                if (!v0 && q0.size() > 0 && $urandom_range(99) < valid_pct) begin
                    d0 = q0.pop_front(); v0 = 1;
                end
                if (!v1 && q1.size() > 0 && $urandom_range(99) < valid_pct) begin
                    d1 = q1.pop_front(); v1 = 1;
                end
            end
            rr = rr_hold ? 1'b0 : ($urandom_range(99) < rr_pct);
        end
    end

    // Monitor / reference model.
    bit busy = 0;
    bit lg = 1;
    bit prev_rv = 0, prev_rr = 0, prev_id = 0;
    int prev_rc = 0;
    int w0 = 0, w1 = 0;

    always @(negedge clk) begin
        bit e0, e1;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            chk("reset_res_valid", rv, 0);
            chk("reset_res_count", rc, 0);
            chk("reset_res_id", rid, 0);
            chk("reset_ready0", r0, 0);
            chk("reset_ready1", r1, 0);
            sb.delete();
            busy = 0; lg = 1; prev_rv = 0; prev_rr = 0; w0 = 0; w1 = 0;
        end else begin
            e0 = !busy && v0 && (!v1 || lg);
            e1 = !busy && v1 && (!v0 || !lg);
            chk("ready0", r0, e0);
            chk("ready1", r1, e1);
            if (e0 || e1) begin
                e.id  = e1;
                e.cnt = e1 ? $countones(d1) : $countones(d0);
                e.t   = cyc;
                sb.push_back(e);
                lg = e1; busy = 1; acc_cnt++;
                if (e1) begin
                    acc1 = 1; w1 = 0;
                    if (v0) begin w0++; chk("fair_wait0", (w0 <= 1), 1); end
                end else begin
                    acc0 = 1; w0 = 0;
                    if (v1) begin w1++; chk("fair_wait1", (w1 <= 1), 1); end
                end
            end
            if (prev_rv && !prev_rr) begin
                chk("hold_valid", rv, 1);
                chk("hold_count", rc, prev_rc);
                chk("hold_id", rid, prev_id);
            end
            if (prev_rv && prev_rr) chk("valid_drop", rv, 0);
            if (rv && !prev_rv) begin
                if (sb.size() == 0) chk("spurious_result", 1, 0);
                else chk("latency", cyc - sb[0].t, CHUNKS + 1);
            end
            if (rv && rr && sb.size() > 0) begin
                e = sb.pop_front();
                chk("res_count", rc, e.cnt);
                chk("res_id", rid, e.id);
                busy = 0;
                res_cnt++;
            end
            prev_rv = rv; prev_rr = rr; prev_rc = rc; prev_id = rid;
        end
    end

    task automatic wait_results(int target, int budget);
        int n = 0;
        while (res_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("results_timeout", (res_cnt >= target), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 0;
        #20;
        @(posedge clk);
        #3 rst_n = 1;
    endtask

    initial begin
        int target, n, start;
        rst_n = 0;
        #23 rst_n = 1;

        // Single requester cases
        q0.push_back(28'h0FFFFFFF);
        wait_results(1, 40);
        q1.push_back(28'h0AAAAAAA);
        q1.push_back(28'h0000000);
        wait_results(3, 60);

        // Contention from reset: 0, 1, then 0 again
        do_reset();
        target = res_cnt;
        q0.push_back(28'h000007F);
        q1.push_back(28'h0000003);
        wait_results(target + 2, 60);
        q0.push_back(28'h0123456);
        q1.push_back(28'h0FEDCBA);
        wait_results(target + 4, 60);

        // Backpressure
        rr_hold = 1;
        q0.push_back(28'h0555555);
        n = 0;
        while (!rv && n < 40) begin @(negedge clk); n++; end
        chk("bp_valid_seen", rv, 1);
        repeat (3) @(negedge clk);
        rr_hold = 0;
        wait_results(target + 5, 40);

        // Reset in the second RUN cycle
        start = acc_cnt;
        q0.push_back(28'h0FFFFFFF);
        n = 0;
        while (acc_cnt == start && n < 40) begin
            @(posedge clk); #2; n++;
        end
        chk("rst_test_accept", (acc_cnt != start), 1);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("async_rst_valid", rv, 0);
        chk("async_rst_count", rc, 0);
        chk("async_rst_id", rid, 0);
        chk("async_rst_ready0", r0, 0);
        chk("async_rst_ready1", r1, 0);
        #20 rst_n = 1;
        repeat (10) @(negedge clk);
        target = res_cnt;
        q1.push_back(28'h0000001);
        wait_results(target + 1, 40);

        // Random regression
        valid_pct = 40;
        rr_pct = 60;
        target = res_cnt + 1000;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            if ($urandom_range(1) == 1) q1.push_back(w);
            else q0.push_back(w);
        end
        wait_results(target, 40000);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/popcount_sched.md
# popcount_sched

Round-robin scheduler that shares one instance of the existing 7-input `ones` counter between two requesters. Each requester submits a 28-bit word. The block serialises the word into four 7-bit chunks, drives one chunk per cycle through the shared counter and accumulates the total. It returns the population count with a requester tag over a valid/ready handshake. It sits between the requesting datapaths and the shared `ones` datapath, and is the only driver of that datapath's input.

## Interface
- `CHUNKS`, 4: number of 7-bit chunks per word; word width = 7*CHUNKS.
- `CNT_W`, 5: result width, ceil(log2(7*CHUNKS+1)); 5 for the default.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  7*CHUNKS  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_count`  out  CNT_W  number of ones in the accepted word.
- `res_id`  out  1  requester that owns the result.

## Operation
- Reset values: FSM in IDLE, `req0_ready`=`req1_ready`=0, `res_valid`=0, `res_count`=0, `res_id`=0, chunk index=0, `last_grant`=1 so requester 0 wins first.
- The FSM has three states:
  - IDLE:
    - If exactly one `reqN_valid` is high, grant it.
    - If both are high, grant the requester other than `last_grant`.
    - The granted `reqN_ready` is driven high combinationally in that same cycle. This is the acceptance cycle.
    - On acceptance: latch data into a word register, set `res_id`=N, clear the accumulator, clear the index, set `last_grant`=N, go to RUN.
    - With no valid input, stay in IDLE with both readies low.
  - RUN:
    - Drive `ones` input with word[7*idx+6 : 7*idx].
    - Accumulator += the 3-bit `ones` output, zero-extended to CNT_W.
    - idx increments each cycle. At idx=CHUNKS-1, register the final sum into `res_count` and go to DONE.
  - DONE:
    - `res_valid`=1; `res_count` and `res_id` are held stable.
    - On `res_valid` && `res_ready`, go to IDLE and drop `res_valid` in the next cycle.
- Both readies are 0 outside IDLE. No word is accepted while one is in flight or a result is pending.
- The accumulator cannot overflow: the maximum is 7*CHUNKS, which fits in CNT_W.
- Requester data must stay stable only during the acceptance cycle, because the block registers it.
- A reset assertion in any state returns the block to its reset values immediately. The in-flight word and any pending result are discarded and not replayed.

## Timing
- Acceptance in cycle T. RUN occupies cycles T+1 .. T+CHUNKS. `res_valid` rises in cycle T+CHUNKS+1 (cycle T+5 for the default).
- If `res_ready` is high in the first DONE cycle, IDLE is reached at T+CHUNKS+2. The next acceptance can occur in that cycle.
- Throughput is one word per CHUNKS+2 cycles with no backpressure.
- `reqN_ready` has a combinational path from `reqN_valid`. Requesters must not make `valid` depend on `ready`.
- `ones` is purely combinational, so there is one chunk per cycle with no extra pipeline stage.

## Structure
- Shared package holds:
  - constant `CHUNK_W`=7;
  - FSM state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default `CHUNKS` and `CNT_W`.
- One sub-module: the existing `ones` block, instantiated once and unmodified.
- The arbiter is a few lines inside IDLE decode and does not need its own module.

## Test plan
- Requester 0 only, data 28'h0FFFFFFF:
  - `req0_ready` is high in cycle T.
  - `res_valid` is high at T+5 with `res_count`=28 and `res_id`=0.
- Requester 1 only, data 28'h0AAAAAAA → `res_count`=14, `res_id`=1. Data 28'h0 → `res_count`=0.
- Both requesters valid at once, out of reset, with data0=28'h000007F and data1=28'h0000003:
  - The first result is count 7, id 0.
  - Requester 1 is accepted in the next IDLE; its result is count 2, id 1.
  - Repeat with both valid again: requester 0 is granted next, confirming alternation.
- Backpressure: hold `res_ready`=0 for 3 cycles after `res_valid` rises.
  - `res_valid`, `res_count` and `res_id` stay stable.
  - Both readies stay 0 throughout.
  - Release `res_ready`: `res_valid` drops in the next cycle.
- Reset mid-operation: assert `rst_n`=0 in the second RUN cycle.
  - All outputs go to reset values immediately.
  - After release, no stale result appears.
  - A new requester 1 word with data 28'h0000001 completes with count 1.
- Random regression: 1000 random words with random valid and `res_ready` patterns on both requesters.
  - Every `res_count` matches a reference popcount.
  - Results arrive in acceptance order.
  - No requester waits more than one other transaction when both stay valid.
